// File: rtl/trace_pkg.sv
// Shared types and constants for the UART debug-trace packer: FSM encoding,
// default framing constants and the frame-length helper.
package trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEQ,
        ST_IDX,
        ST_DATA,
        ST_CHK
    } state_e;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;
    localparam int         DW_DEFAULT  = 32;
    localparam int         BPW         = DW_DEFAULT / 8;

    // Bytes on the wire: HDR, SEQ, CHK plus an index byte and a word per enabled channel.
    function automatic int frame_len(input int n_enabled, input int bytes_per_word);
        return 3 + n_enabled * (1 + bytes_per_word);
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser, LSB first, idle high. ready_o is also high in the
// last cycle of the stop bit so consecutive bytes leave with no idle gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       qclk,
    input  logic       resetn,
    input  logic [7:0] byte_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int CCW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic           active_q, active_d;
    logic           tx_q, tx_d;
    logic [8:0]     shift_q, shift_d;
    logic [3:0]     bit_q, bit_d;
    logic [CCW-1:0] clk_cnt_q, clk_cnt_d;
    logic           bit_end;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        active_d  = active_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        clk_cnt_d = clk_cnt_q;
        bit_end   = (clk_cnt_q == CCW'(CLKS_PER_BIT - 1));
        ready_o   = !active_q || (bit_end && (bit_q == 4'd9));

        if (valid_i && ready_o) begin
            active_d  = 1'b1;
            tx_d      = 1'b0;
            shift_d   = {1'b1, byte_i};
            bit_d     = 4'd0;
            clk_cnt_d = '0;
        end else if (active_q) begin
            if (bit_end) begin
                clk_cnt_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge qclk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            active_q  <= 1'b0;
            tx_q      <= 1'b1;
            shift_q   <= '1;
            bit_q     <= 4'd0;
            clk_cnt_q <= '0;
        end else begin
            active_q  <= active_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            clk_cnt_q <= clk_cnt_d;
        end
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/uart_trace_packer.sv
// Debug-trace packer: snapshots enabled channel words on send_i and emits
// one framed, XOR-checksummed, sequence-numbered packet over a UART line.
module uart_trace_packer
    import trace_pkg::*;
#(
    parameter int         NCH          = 8,
    parameter int         DW           = DW_DEFAULT,
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HDR          = HDR_DEFAULT
) (
    input  logic              qclk,
    input  logic              resetn,
    input  logic              send_i,
    input  logic [NCH*DW-1:0] ch_data_i,
    input  logic [NCH-1:0]    ch_en_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              drop_o,
    output logic [7:0]        seq_o
);

    localparam int WORD_BYTES = DW / 8;
    localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BCW        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    state_e            state_q, state_d;
    logic [7:0]        seq_q, seq_d;
    logic              drop_q, drop_d;
    logic              done_q, done_d;
    logic [7:0]        chk_q, chk_d;
    logic              chk_sent_q, chk_sent_d;
    logic [CW-1:0]     ch_idx_q, ch_idx_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [NCH*DW-1:0] data_q, data_d;
    logic [NCH-1:0]    en_q, en_d;

    logic              tx_valid, tx_ready;
    logic [7:0]        tx_byte, cur_byte;
    logic              found;
    logic [CW-1:0]     next_ch;
    int                scan_start;

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        drop_d     = drop_q;
        done_d     = 1'b0;
        chk_d      = chk_q;
        chk_sent_d = chk_sent_q;
        ch_idx_d   = ch_idx_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        en_d       = en_q;
        tx_valid   = 1'b0;
        tx_byte    = 8'h00;

        // Lowest enabled channel at or above the scan start; SEQ restarts the scan at 0.
        scan_start = (state_q == ST_SEQ) ? 0 : int'(ch_idx_q) + 1;
        found      = 1'b0;
        next_ch    = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (en_q[c] && (c >= scan_start)) begin
                found   = 1'b1;
                next_ch = CW'(c);
            end
        end
        cur_byte = data_q[int'(ch_idx_q) * DW + int'(byte_cnt_q) * 8 +: 8];

        if ((state_q != ST_IDLE) && send_i) drop_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (send_i) begin
                    data_d     = ch_data_i;
                    en_d       = ch_en_i;
                    chk_d      = 8'h00;
                    chk_sent_d = 1'b0;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_byte  = HDR;
                if (tx_ready) state_d = ST_SEQ;
            end
            ST_SEQ: begin
                tx_valid = 1'b1;
                tx_byte  = seq_q;
                if (tx_ready) begin
                    chk_d    = seq_q;
                    ch_idx_d = next_ch;
                    state_d  = found ? ST_IDX : ST_CHK;
                end
            end
            ST_IDX: begin
                tx_valid = 1'b1;
                tx_byte  = 8'(ch_idx_q);
                if (tx_ready) begin
                    chk_d      = chk_q ^ tx_byte;
                    byte_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_valid = 1'b1;
                tx_byte  = cur_byte;
                if (tx_ready) begin
                    chk_d = chk_q ^ cur_byte;
                    if (byte_cnt_q == BCW'(WORD_BYTES - 1)) begin
                        ch_idx_d = next_ch;
                        state_d  = found ? ST_IDX : ST_CHK;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            ST_CHK: begin
                // Serialiser ready after the checksum was handed over means its stop bit is ending.
                if (!chk_sent_q) begin
                    tx_valid = 1'b1;
                    tx_byte  = chk_q;
                    if (tx_ready) chk_sent_d = 1'b1;
                end else if (tx_ready) begin
                    chk_sent_d = 1'b0;
                    done_d     = 1'b1;
                    seq_d      = seq_q + 8'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge qclk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            seq_q      <= 8'h00;
            drop_q     <= 1'b0;
            done_q     <= 1'b0;
            chk_q      <= 8'h00;
            chk_sent_q <= 1'b0;
            ch_idx_q   <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            done_q     <= done_d;
            chk_q      <= chk_d;
            chk_sent_q <= chk_sent_d;
            ch_idx_q   <= ch_idx_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // NOTE: the shadow registers are plain datapath storage reloaded on every accepted send, so they carry no reset.
    always_ff @(posedge qclk) begin
        data_q <= data_d;
        en_q   <= en_d;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .qclk   (qclk),
        .resetn (resetn),
        .byte_i (tx_byte),
        .valid_i(tx_valid),
        .ready_o(tx_ready),
        .tx_o   (tx_o)
    );

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;
    assign drop_o = drop_q;
    assign seq_o  = seq_q;

endmodule

// File: tb/tb_uart_trace_packer.sv
// Randomised self-checking bench for uart_trace_packer: a UART monitor decodes
// tx_o and frames are compared against a byte-level model of the packet format.
module tb_uart_trace_packer;
    import trace_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int C   = 4;

    logic              qclk = 1'b0;
    logic              resetn = 1'b0;
    logic              send_i = 1'b0;
    logic [NCH*DW-1:0] ch_data_i = '0;
    logic [NCH-1:0]    ch_en_i = '0;
    logic              tx_o, busy_o, done_o, drop_o;
    logic [7:0]        seq_o;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] model_seq;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] last_rx[$];

    uart_trace_packer #(
        .NCH(NCH), .DW(DW), .CLKS_PER_BIT(C)
    ) dut (
        .qclk(qclk), .resetn(resetn), .send_i(send_i), .ch_data_i(ch_data_i),
        .ch_en_i(ch_en_i), .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o),
        .drop_o(drop_o), .seq_o(seq_o)
    );

    always #5 qclk = ~qclk;
    always @(posedge qclk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // UART receiver: samples mid-bit on falling edges, records byte and start-bit edge.
    initial begin
        logic [7:0] b;
        int         t0;
        forever begin
            @(negedge qclk);
            if (tx_o === 1'b0) begin
                t0 = cyc;
                repeat (C / 2) @(negedge qclk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge qclk);
                    b[i] = tx_o;
                end
                repeat (C) @(negedge qclk);
                check("stop_bit", 32'(tx_o), 32'd1);
                rx_q.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    // Reference frame: HDR, SEQ, (index, word LSB first) per enabled channel, XOR checksum.
    task automatic build_expected(input logic [NCH-1:0] mask, input logic [NCH*DW-1:0] data);
        logic [7:0] x, w;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(model_seq);
        x = model_seq;
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                exp_q.push_back(8'(c));
                x ^= 8'(c);
                for (int j = 0; j < DW / 8; j++) begin
                    w = 8'(data >> (c * DW + j * 8));
                    exp_q.push_back(w);
                    x ^= w;
                end
            end
        end
        exp_q.push_back(x);
    endtask

    task automatic compare_frame(input string tag, input int k);
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        if (rx_q.size() > 0) check({tag, "_start"}, 32'(rx_t[0]), 32'(k + 1));
        last_rx = rx_q;
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic wait_done(output int e, output bit ok);
        int i;
        ok = 1'b0;
        e  = 0;
        i  = 0;
        while (!ok && i < 20000) begin
            @(negedge qclk);
            if (done_o) begin
                ok = 1'b1;
                e  = cyc;
            end
            i++;
        end
    endtask

    task automatic do_reset();
        @(negedge qclk);
        resetn = 1'b0;
        send_i = 1'b0;
        repeat (2) @(negedge qclk);
        resetn = 1'b1;
        model_seq = 8'h00;
        repeat (12 * C) @(negedge qclk);
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic do_frame(input string tag, input logic [NCH-1:0] mask,
                            input logic [NCH*DW-1:0] data, input bit mid_drop);
        int k, e, len;
        bit ok;
        @(negedge qclk);
        ch_en_i   = mask;
        ch_data_i = data;
        send_i    = 1'b1;
        build_expected(mask, data);
        len = frame_len($countones(mask), BPW);
        k   = cyc + 1;
        @(negedge qclk);
        send_i = 1'b0;
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
        check({tag, "_tx_hold"}, 32'(tx_o), 32'd1);
        if (mid_drop) begin
            repeat (20) @(negedge qclk);
            ch_data_i[31:0] = 32'hFFFF_FFFF;
            send_i = 1'b1;
            @(negedge qclk);
            send_i = 1'b0;
            check({tag, "_drop"}, 32'(drop_o), 32'd1);
        end
        wait_done(e, ok);
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        check({tag, "_done_edge"}, 32'(e), 32'(k + 1 + 10 * C * len));
        check({tag, "_busy_fall"}, 32'(busy_o), 32'd0);
        model_seq = model_seq + 8'd1;
        check({tag, "_seq"}, 32'(seq_o), 32'(model_seq));
        compare_frame(tag, k);
        @(negedge qclk);
        check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    endtask

    function automatic logic [NCH*DW-1:0] rand_data();
        logic [NCH*DW-1:0] d;
        for (int i = 0; i < NCH; i++) d[i*DW +: DW] = $urandom();
        return d;
    endfunction

    initial begin
        int k, e, saw;
        bit ok;
        model_seq = 8'h00;
        repeat (3) @(negedge qclk);
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_drop", 32'(drop_o), 32'd0);
        check("rst_seq", 32'(seq_o), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge qclk);

        // Single channel, with a snapshot-changing send that must only raise drop_o.
        do_frame("single", 4'b0001, {96'h0, 32'h1234_5678}, 1'b1);
        check("single_chk_const", 32'(last_rx[7]), 32'h08);
        check("single_d0_const", 32'(last_rx[3]), 32'h78);
        repeat (100) @(negedge qclk);
        check("no_second_frame", 32'(rx_q.size()), 32'd0);
        check("idle_after_drop", 32'(busy_o), 32'd0);
        check("drop_sticky", 32'(drop_o), 32'd1);

        do_reset();
        check("drop_cleared", 32'(drop_o), 32'd0);
        do_frame("empty", 4'b0000, rand_data(), 1'b0);

        do_reset();
        do_frame("skip", 4'b1010, {32'h0000_0001, 32'h0, 32'hAABB_CCDD, 32'h0}, 1'b0);
        check("skip_idx3_const", 32'(last_rx[7]), 32'h03);

        for (int n = 0; n < 6; n++)
            do_frame($sformatf("rand%0d", n), 4'($urandom_range(0, 15)), rand_data(), 1'b0);

        // Reset during the third byte of a frame.
        @(negedge qclk);
        ch_en_i   = 4'hF;
        ch_data_i = rand_data();
        send_i    = 1'b1;
        k         = cyc + 1;
        @(negedge qclk);
        send_i = 1'b0;
        while (cyc < k + 1 + 20 * C + 6) @(negedge qclk);
        resetn = 1'b0;
        @(negedge qclk);
        check("abort_tx", 32'(tx_o), 32'd1);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_seq", 32'(seq_o), 32'd0);
        resetn = 1'b1;
        model_seq = 8'h00;
        saw = 0;
        repeat (15 * C) begin
            @(negedge qclk);
            if (done_o) saw++;
        end
        check("abort_no_done", 32'(saw), 32'd0);
        rx_q.delete();
        rx_t.delete();
        do_frame("post_abort", 4'($urandom_range(1, 15)), rand_data(), 1'b0);
        check("post_abort_seq0", 32'(last_rx[1]), 32'h00);

        // send_i held high: 257 back-to-back empty frames, SEQ wraps.
        do_reset();
        @(negedge qclk);
        ch_en_i = 4'b0000;
        send_i  = 1'b1;
        k       = cyc + 1;
        for (int n = 0; n < 257; n++) begin
            build_expected(4'b0000, ch_data_i);
            wait_done(e, ok);
            if (n == 256) send_i = 1'b0;
            check("wrap_done_seen", 32'(ok), 32'd1);
            check("wrap_done_edge", 32'(e), 32'(k + 1 + 10 * C * 3));
            model_seq = model_seq + 8'd1;
            compare_frame($sformatf("wrap%0d", n), k);
            k = e + 1;
        end
        check("wrap_seq_end", 32'(seq_o), 32'd1);
        check("wrap_drop", 32'(drop_o), 32'd1);
        repeat (100) @(negedge qclk);
        check("wrap_stopped", 32'(busy_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
